wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage of the MangoMIPS32 core. It sits directly downstream of the MEM/WB pipeline register and consumes its outputs.
- Load-data alignment and extension, result selection, and generation of the GPR write port.
- Owns the architectural HI/LO pair and the LLbit register, with same-cycle bypass outputs for upstream readers.
- Provides a retired-instruction counter.

Parameters:
ALUOP_W, 8, width of wb_aluop; op codes are the core's ALU_* constants
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wb_pc  in  32  PC of instruction in WB; 0 denotes bubble
wb_aluop  in  ALUOP_W  operation code
wb_alures  in  32  ALU result
wb_mulres  in  32  low word of product (MUL)
wb_m_vaddr  in  32  load virtual address
wb_m_rdata  in  32  raw memory read word (little-endian)
wb_wreg  in  4  per-byte GPR write enables
wb_wraddr  in  5  destination GPR
wb_hilo_wen  in  1  write HI/LO this cycle
wb_hilo  in  64  {HI,LO} value to write
wb_llb_wen  in  1  write LLbit this cycle
wb_llbit  in  1  LLbit value to write
llb_clr  in  1  ERET/exception clears LLbit
rf_wen  out  4  per-byte GPR write enables (combinational)
rf_waddr  out  5  GPR write address (combinational)
rf_wdata  out  32  GPR write data (combinational)
hi  out  32  HI register
lo  out  32  LO register
hi_fwd  out  32  bypassed HI
lo_fwd  out  32  bypassed LO
llbit  out  1  LLbit register
llbit_fwd  out  1  bypassed LLbit
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at clock edge): hi=0, lo=0, llbit=0, retired=0. Reset has priority over every write in the same cycle. Combinational outputs follow their inputs even during reset.
- rf_waddr=wb_wraddr.
- rf_wen=wb_wreg, except for LWL/LWR, where rf_wen=wb_wreg & mask.
- k=wb_m_vaddr[1:0]. bytes: b_i=wb_m_rdata[8i+7:8i].
- rf_wdata selection by wb_aluop:
  - ALU_LB: sign-extend b_k.
  - ALU_LBU: zero-extend b_k.
  - ALU_LH: sign-extend halfword at vaddr[1] (vaddr[1]=0 gives rdata[15:0], =1 gives rdata[31:16]). vaddr[0] is ignored; alignment is trapped upstream.
  - ALU_LHU: as ALU_LH, zero-extended.
  - ALU_LW, ALU_LL: rdata.
  - ALU_LWL: rdata << 8*(3-k); mask = top k+1 bytes set (k=0 gives 4'b1000, k=3 gives 4'b1111).
  - ALU_LWR: rdata >> 8*k; mask = low 4-k bytes set (k=0 gives 4'b1111, k=3 gives 4'b0001).
  - ALU_MUL: wb_mulres.
  - All others: wb_alures.
- HI/LO:
  - When wb_hilo_wen=1 at a clock edge: hi<=wb_hilo[63:32], lo<=wb_hilo[31:0].
  - hi_fwd/lo_fwd = wb_hilo_wen ? incoming halves : registered values (zero-latency bypass).
- LLbit:
  - Priority: rst > llb_clr > wb_llb_wen.
  - llb_clr=1 forces llbit<=0 even if wb_llb_wen=1 in the same cycle.
  - llbit_fwd = llb_clr ? 0 : (wb_llb_wen ? wb_llbit : llbit).
- retired:
  - Increments by 1 each cycle wb_pc!=0; holds on bubbles.
  - Wraps modulo 2^CNT_W without flagging.
- No stall input: the upstream register holds a stalled instruction with wreg=0 and hilo_wen=0. Holding a bubble or the same instruction therefore writes nothing new, except that retired counts every cycle wb_pc!=0.

Test Plan:
- Reset: assert rst 1 cycle after hilo/llbit writes -> hi=lo=0, llbit=0, retired=0 next cycle; a write coincident with rst is dropped.
- Byte/half loads: rdata=0x807F_F001 with LB at k=3, LBU k=3, LH vaddr[1]=1, LHU vaddr[1]=0 -> rf_wdata 0xFFFF_FF80, 0x0000_0080, 0xFFFF_807F, 0x0000_F001; rf_wen=wb_wreg.
- Unaligned loads: rdata=0x4433_2211, wb_wreg=4'hF. LWL k=1 -> wdata[31:16]=0x2211, rf_wen=4'b1100. LWR k=1 -> wdata[23:0]=0x443322, rf_wen=4'b0111. LWL k=3 -> full word, rf_wen=4'hF.
- HI/LO bypass: wb_hilo_wen=1, wb_hilo=0x1234_5678_9ABC_DEF0 -> same cycle hi_fwd=0x1234_5678, lo_fwd=0x9ABC_DEF0, hi/lo unchanged; next cycle hi/lo equal those values with wen=0.
- LLbit: LL sets llbit=1; next cycle wb_llb_wen=1 with wb_llbit=1 and llb_clr=1 together -> llbit_fwd=0 and llbit=0 after edge.
- Counter: 5 cycles pc=0xBFC0_0000.. interleaved with 3 cycles pc=0 -> retired=5. With CNT_W=4, start at 15 plus one valid -> retired=0.

Source files
------------

// File: rtl/wb_stage.sv
// MangoMIPS32 writeback stage: load alignment/extension, GPR write port,
// architectural HI/LO and LLbit with same-cycle bypass, retired counter.
module wb_stage #(
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        wb_pc,
  input  logic [ALUOP_W-1:0] wb_aluop,
  input  logic [31:0]        wb_alures,
  input  logic [31:0]        wb_mulres,
  input  logic [31:0]        wb_m_vaddr,
  input  logic [31:0]        wb_m_rdata,
  input  logic [3:0]         wb_wreg,
  input  logic [4:0]         wb_wraddr,
  input  logic               wb_hilo_wen,
  input  logic [63:0]        wb_hilo,
  input  logic               wb_llb_wen,
  input  logic               wb_llbit,
  input  logic               llb_clr,
  output logic [3:0]         rf_wen,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic [31:0]        hi_fwd,
  output logic [31:0]        lo_fwd,
  output logic               llbit,
  output logic               llbit_fwd,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(8'h30);
  localparam logic [ALUOP_W-1:0] ALU_LB  = ALUOP_W'(8'h50);
  localparam logic [ALUOP_W-1:0] ALU_LBU = ALUOP_W'(8'h51);
  localparam logic [ALUOP_W-1:0] ALU_LH  = ALUOP_W'(8'h52);
  localparam logic [ALUOP_W-1:0] ALU_LHU = ALUOP_W'(8'h53);
  localparam logic [ALUOP_W-1:0] ALU_LW  = ALUOP_W'(8'h54);
  localparam logic [ALUOP_W-1:0] ALU_LWL = ALUOP_W'(8'h55);
  localparam logic [ALUOP_W-1:0] ALU_LWR = ALUOP_W'(8'h56);
  localparam logic [ALUOP_W-1:0] ALU_LL  = ALUOP_W'(8'h57);

  function automatic logic [31:0] ext_byte(input logic [31:0] w,
                                           input logic [1:0]  k,
                                           input logic        sgn);
    logic        [7:0] b;
    logic signed [7:0] sb;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    sb = signed'(b);
    return sgn ? 32'(sb) : {24'b0, b};
  endfunction

  // Halfword alignment faults are trapped upstream, so only vaddr[1] matters.
  function automatic logic [31:0] ext_half(input logic [31:0] w,
                                           input logic        upper,
                                           input logic        sgn);
    logic        [15:0] h;
    logic signed [15:0] sh;
    h  = upper ? w[31:16] : w[15:0];
    sh = signed'(h);
    return sgn ? 32'(sh) : {16'b0, h};
  endfunction

  function automatic logic [31:0] lwl_word(input logic [31:0] w,
                                           input logic [1:0]  k);
    case (k)
      2'd0:    return {w[7:0],  24'b0};
      2'd1:    return {w[15:0], 16'b0};
      2'd2:    return {w[23:0], 8'b0};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] lwr_word(input logic [31:0] w,
                                           input logic [1:0]  k);
    case (k)
      2'd0:    return w;
      2'd1:    return {8'b0,  w[31:8]};
      2'd2:    return {16'b0, w[31:16]};
      default: return {24'b0, w[31:24]};
    endcase
  endfunction

  function automatic logic [3:0] lwl_mask(input logic [1:0] k);
    case (k)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b1100;
      2'd2:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] lwr_mask(input logic [1:0] k);
    case (k)
      2'd0:    return 4'b1111;
      2'd1:    return 4'b0111;
      2'd2:    return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  logic [1:0] k;
  logic       unused_vaddr;

  assign k            = wb_m_vaddr[1:0];
  assign unused_vaddr = ^wb_m_vaddr[31:2];

  always_comb begin
    rf_waddr = wb_wraddr;
    rf_wen   = wb_wreg;
    rf_wdata = wb_alures;
    case (wb_aluop)
      ALU_LB:  rf_wdata = ext_byte(wb_m_rdata, k, 1'b1);
      ALU_LBU: rf_wdata = ext_byte(wb_m_rdata, k, 1'b0);
      ALU_LH:  rf_wdata = ext_half(wb_m_rdata, k[1], 1'b1);
      ALU_LHU: rf_wdata = ext_half(wb_m_rdata, k[1], 1'b0);
      ALU_LW,
      ALU_LL:  rf_wdata = wb_m_rdata;
      ALU_LWL: begin
        rf_wdata = lwl_word(wb_m_rdata, k);
        rf_wen   = wb_wreg & lwl_mask(k);
      end
      ALU_LWR: begin
        rf_wdata = lwr_word(wb_m_rdata, k);
        rf_wen   = wb_wreg & lwr_mask(k);
      end
      ALU_MUL: rf_wdata = wb_mulres;
      default: rf_wdata = wb_alures;
    endcase
  end

  // Bypass paths let EX read the value being committed this very cycle.
  assign hi_fwd    = wb_hilo_wen ? wb_hilo[63:32] : hi;
  assign lo_fwd    = wb_hilo_wen ? wb_hilo[31:0]  : lo;
  assign llbit_fwd = llb_clr ? 1'b0 : (wb_llb_wen ? wb_llbit : llbit);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      llbit   <= 1'b0;
      retired <= '0;
    end else begin
      if (wb_hilo_wen) begin
        hi <= wb_hilo[63:32];
        lo <= wb_hilo[31:0];
      end
      if (llb_clr)
        llbit <= 1'b0;
      else if (wb_llb_wen)
        llbit <= wb_llbit;
      // A zero PC marks a bubble; counter wraps silently.
      if (wb_pc != 32'd0)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, corner-case sequences and
// randomized stimulus against a behavioural reference model.
module tb_wb_stage;

  localparam logic [7:0] OP_MUL = 8'h30, OP_LB = 8'h50, OP_LBU = 8'h51,
                         OP_LH = 8'h52, OP_LHU = 8'h53, OP_LW = 8'h54,
                         OP_LWL = 8'h55, OP_LWR = 8'h56, OP_LL = 8'h57,
                         OP_ADD = 8'h21;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_pc, wb_alures, wb_mulres, wb_m_vaddr, wb_m_rdata;
  logic [7:0]  wb_aluop;
  logic [3:0]  wb_wreg;
  logic [4:0]  wb_wraddr;
  logic        wb_hilo_wen, wb_llb_wen, wb_llbit, llb_clr;
  logic [63:0] wb_hilo;

  logic [3:0]  rf_wen, rf_wen4;
  logic [4:0]  rf_waddr, rf_waddr4;
  logic [31:0] rf_wdata, rf_wdata4, hi, lo, hi_fwd, lo_fwd;
  logic [31:0] hi4, lo4, hi_fwd4, lo_fwd4, retired;
  logic        llbit, llbit_fwd, llbit4, llbit_fwd4;
  logic [3:0]  retired4;

  int errors = 0;
  int checks = 0;

  // reference-model state
  logic [31:0] m_hi, m_lo, m_ret;
  logic        m_llb;
  logic [3:0]  m_ret4;

  always #5 clk = ~clk;

  wb_stage #(.ALUOP_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_aluop(wb_aluop),
    .wb_alures(wb_alures), .wb_mulres(wb_mulres), .wb_m_vaddr(wb_m_vaddr),
    .wb_m_rdata(wb_m_rdata), .wb_wreg(wb_wreg), .wb_wraddr(wb_wraddr),
    .wb_hilo_wen(wb_hilo_wen), .wb_hilo(wb_hilo), .wb_llb_wen(wb_llb_wen),
    .wb_llbit(wb_llbit), .llb_clr(llb_clr), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi(hi), .lo(lo),
    .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .llbit(llbit), .llbit_fwd(llbit_fwd),
    .retired(retired));

  wb_stage #(.ALUOP_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_aluop(wb_aluop),
    .wb_alures(wb_alures), .wb_mulres(wb_mulres), .wb_m_vaddr(wb_m_vaddr),
    .wb_m_rdata(wb_m_rdata), .wb_wreg(wb_wreg), .wb_wraddr(wb_wraddr),
    .wb_hilo_wen(wb_hilo_wen), .wb_hilo(wb_hilo), .wb_llb_wen(wb_llb_wen),
    .wb_llbit(wb_llbit), .llb_clr(llb_clr), .rf_wen(rf_wen4),
    .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4), .hi(hi4), .lo(lo4),
    .hi_fwd(hi_fwd4), .lo_fwd(lo_fwd4), .llbit(llbit4),
    .llbit_fwd(llbit_fwd4), .retired(retired4));

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference load path: byte lanes extracted with shifts, signedness by
  // subtracting the lane's range.
  function automatic logic [31:0] ref_wdata(input logic [7:0] op,
      input logic [31:0] va, input logic [31:0] rd,
      input logic [31:0] alu, input logic [31:0] mul);
    int unsigned k;
    longint v;
    k = va % 4;
    case (op)
      OP_LB, OP_LBU: begin
        v = (rd >> (8 * k)) & 32'hFF;
        if (op == OP_LB && v >= 128) v = v - 256;
        return 32'(v);
      end
      OP_LH, OP_LHU: begin
        v = (va[1] ? (rd >> 16) : rd) & 32'hFFFF;
        if (op == OP_LH && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      OP_LW, OP_LL: return rd;
      OP_LWL: return rd << (8 * (3 - k));
      OP_LWR: return rd >> (8 * k);
      OP_MUL: return mul;
      default: return alu;
    endcase
  endfunction

  function automatic logic [3:0] ref_wen(input logic [7:0] op,
      input logic [31:0] va, input logic [3:0] wreg);
    int unsigned k;
    k = va % 4;
    if (op == OP_LWL) return wreg & 4'(((1 << (k + 1)) - 1) << (3 - k));
    if (op == OP_LWR) return wreg & 4'((1 << (4 - k)) - 1);
    return wreg;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rf_wen"},    rf_wen,   ref_wen(wb_aluop, wb_m_vaddr, wb_wreg));
    chk({tag, ".rf_waddr"},  rf_waddr, wb_wraddr);
    chk({tag, ".rf_wdata"},  rf_wdata,
        ref_wdata(wb_aluop, wb_m_vaddr, wb_m_rdata, wb_alures, wb_mulres));
    chk({tag, ".hi"},        hi,       m_hi);
    chk({tag, ".lo"},        lo,       m_lo);
    chk({tag, ".hi_fwd"},    hi_fwd,   wb_hilo_wen ? wb_hilo[63:32] : m_hi);
    chk({tag, ".lo_fwd"},    lo_fwd,   wb_hilo_wen ? wb_hilo[31:0] : m_lo);
    chk({tag, ".llbit"},     llbit,    m_llb);
    chk({tag, ".llbit_fwd"}, llbit_fwd,
        llb_clr ? 1'b0 : (wb_llb_wen ? wb_llbit : m_llb));
    chk({tag, ".retired"},   retired,  m_ret);
    chk({tag, ".retired4"},  retired4, m_ret4);
  endtask

  // Advance one clock, updating the model from the inputs the DUT sees.
  task automatic tick();
    if (rst) begin
      m_hi = 0; m_lo = 0; m_llb = 0; m_ret = 0; m_ret4 = 0;
    end else begin
      if (wb_hilo_wen) begin
        m_hi = wb_hilo[63:32];
        m_lo = wb_hilo[31:0];
      end
      if (llb_clr) m_llb = 0;
      else if (wb_llb_wen) m_llb = wb_llbit;
      if (wb_pc != 0) begin
        m_ret  = m_ret + 1;
        m_ret4 = 4'((m_ret4 + 1) % 16);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_pc = 0; wb_aluop = OP_ADD; wb_alures = 0; wb_mulres = 0;
    wb_m_vaddr = 0; wb_m_rdata = 0; wb_wreg = 0; wb_wraddr = 0;
    wb_hilo_wen = 0; wb_hilo = 0; wb_llb_wen = 0; wb_llbit = 0; llb_clr = 0;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] va;
    logic [31:0] rd;
    logic [3:0]  wreg;
    logic [4:0]  wa;
    logic [31:0] ewd;
    logic [3:0]  ewen;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] ops[10];
  logic [31:0] pcs[8];

  initial begin
    tbl[0]  = '{OP_LB,  32'h1003, 32'h807F_F001, 4'hF, 5'd1,  32'hFFFF_FF80, 4'hF};
    tbl[1]  = '{OP_LBU, 32'h1003, 32'h807F_F001, 4'hF, 5'd2,  32'h0000_0080, 4'hF};
    tbl[2]  = '{OP_LH,  32'h1002, 32'h807F_F001, 4'hF, 5'd3,  32'hFFFF_807F, 4'hF};
    tbl[3]  = '{OP_LHU, 32'h1000, 32'h807F_F001, 4'h3, 5'd4,  32'h0000_F001, 4'h3};
    tbl[4]  = '{OP_LB,  32'h1000, 32'h807F_F001, 4'h1, 5'd5,  32'h0000_0001, 4'h1};
    tbl[5]  = '{OP_LWL, 32'h2001, 32'h4433_2211, 4'hF, 5'd6,  32'h2211_0000, 4'hC};
    tbl[6]  = '{OP_LWR, 32'h2001, 32'h4433_2211, 4'hF, 5'd7,  32'h0044_3322, 4'h7};
    tbl[7]  = '{OP_LWL, 32'h2003, 32'h4433_2211, 4'hF, 5'd8,  32'h4433_2211, 4'hF};
    tbl[8]  = '{OP_LWR, 32'h2003, 32'h4433_2211, 4'hF, 5'd9,  32'h0000_0044, 4'h1};
    tbl[9]  = '{OP_LL,  32'h2000, 32'hCAFE_BABE, 4'hF, 5'd10, 32'hCAFE_BABE, 4'hF};
    tbl[10] = '{OP_MUL, 32'h2000, 32'hCAFE_BABE, 4'hF, 5'd11, 32'h0BAD_F00D, 4'hF};
    tbl[11] = '{OP_ADD, 32'h2000, 32'hCAFE_BABE, 4'hF, 5'd31, 32'h1357_9BDF, 4'hF};
    ops = '{OP_MUL, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL, OP_ADD};
    pcs = '{32'hBFC0_0000, 0, 32'hBFC0_0004, 0, 32'hBFC0_0008, 32'hBFC0_000C, 0,
            32'hBFC0_0010};

    m_hi = 0; m_lo = 0; m_llb = 0; m_ret = 0; m_ret4 = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all("reset");

    // directed load/select vectors
    for (int i = 0; i < 12; i++) begin
      wb_aluop = tbl[i].op; wb_m_vaddr = tbl[i].va; wb_m_rdata = tbl[i].rd;
      wb_wreg = tbl[i].wreg; wb_wraddr = tbl[i].wa;
      wb_alures = 32'h1357_9BDF; wb_mulres = 32'h0BAD_F00D;
      #1;
      chk($sformatf("vec%0d.wdata", i), rf_wdata, tbl[i].ewd);
      chk($sformatf("vec%0d.wen", i),   rf_wen,   tbl[i].ewen);
      chk($sformatf("vec%0d.waddr", i), rf_waddr, tbl[i].wa);
      tick();
    end
    idle_inputs();

    // HI/LO bypass then commit
    wb_hilo_wen = 1; wb_hilo = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("hilo.hi_fwd", hi_fwd, 32'h1234_5678);
    chk("hilo.lo_fwd", lo_fwd, 32'h9ABC_DEF0);
    chk("hilo.hi_old", hi, 32'h0);
    tick();
    wb_hilo_wen = 0; wb_hilo = 0;
    #1;
    chk("hilo.hi", hi, 32'h1234_5678);
    chk("hilo.lo", lo, 32'h9ABC_DEF0);
    chk("hilo.lo_fwd_reg", lo_fwd, 32'h9ABC_DEF0);

    // LLbit set, then set+clear together: clear wins
    wb_llb_wen = 1; wb_llbit = 1;
    tick();
    wb_llb_wen = 0;
    chk("llb.set", llbit, 1'b1);
    wb_llb_wen = 1; wb_llbit = 1; llb_clr = 1;
    #1;
    chk("llb.fwd_clr", llbit_fwd, 1'b0);
    tick();
    idle_inputs();
    chk("llb.cleared", llbit, 1'b0);

    // reset drops a coincident write
    wb_llb_wen = 1; wb_llbit = 1; wb_hilo_wen = 1; wb_hilo = 64'hAAAA_BBBB_CCCC_DDDD;
    wb_pc = 32'hBFC0_0100;
    tick();
    rst = 1; wb_hilo = 64'h1111_2222_3333_4444;
    tick();
    rst = 0; idle_inputs();
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);
    chk("rst.llbit", llbit, 1'b0);
    chk("rst.retired", retired, 32'h0);

    // counter with bubbles, then 4-bit wrap
    for (int i = 0; i < 8; i++) begin
      wb_pc = pcs[i];
      tick();
    end
    wb_pc = 0;
    chk("cnt.five", retired, 32'd5);
    wb_pc = 32'hBFC0_0200;
    for (int i = 0; i < 10; i++) tick();
    chk("cnt4.fifteen", retired4, 4'd15);
    tick();
    wb_pc = 0;
    chk("cnt4.wrap", retired4, 4'd0);
    chk("cnt.sixteen", retired, 32'd16);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      wb_pc       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      wb_aluop    = ops[$urandom_range(0, 9)];
      wb_alures   = $urandom; wb_mulres = $urandom;
      wb_m_vaddr  = $urandom; wb_m_rdata = $urandom;
      wb_wreg     = 4'($urandom); wb_wraddr = 5'($urandom);
      wb_hilo_wen = 1'($urandom); wb_hilo = {$urandom, $urandom};
      wb_llb_wen  = 1'($urandom); wb_llbit = 1'($urandom);
      llb_clr     = ($urandom_range(0, 3) == 0);
      #1;
      check_all($sformatf("rnd%0d", i));
      tick();
    end
    rst = 0; idle_inputs();
    #1;
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
